// File: rtl/aes_link_pkg.sv
// Shared types and constants for the AES SPI link front end.
package aes_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        START,
        WAIT,
        TX
    } link_state_t;

    localparam int unsigned AES_RX_BITS     = 256;
    localparam int unsigned AES_TX_BITS     = 128;
    localparam logic [23:0] AES_TIMEOUT_MAX = 24'hFFFFFF;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, followed by one delay
// flop that turns level changes into single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic int_osc,
    input  logic nreset,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_d;

    // Synchronizer chain plus edge-detect delay stage.
    always_ff @(posedge int_osc or negedge nreset) begin
        if (!nreset) begin
            sync   <= '0;
            sync_d <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], async_in};
            sync_d <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~sync_d;
    assign fall = ~sync[SYNC_STAGES-1] & sync_d;

endmodule

// File: rtl/aes_spi_link.sv
// SPI-slave (mode 0, MSB first) front end for the AES core.
// Shifts in plaintext+key, drives the core, returns the cyphertext on sdo.
// Optional macro AES_SPI_TIMEOUT_EN: abandons WAIT after 2^24-1 cycles
// without core_done and reports the timeout as sdo=1 while idle.
module aes_spi_link
    import aes_link_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RX_BITS     = AES_RX_BITS,
    parameter int unsigned TX_BITS     = AES_TX_BITS
) (
    input  logic         int_osc,
    input  logic         nreset,
    input  logic         sck,
    input  logic         sdi,
    input  logic         mcu_load,
    output logic         sdo,
    output logic         mcu_done,
    output logic         core_load,
    output logic [127:0] core_plaintext,
    output logic [127:0] core_key,
    input  logic         core_done,
    input  logic [127:0] core_cyphertext
);

    localparam int unsigned RX_CW = $clog2(RX_BITS + 1);
    localparam int unsigned TX_CW = $clog2(TX_BITS);

    link_state_t            state, state_next;
    logic                   sck_rise, sck_fall, load_rise, load_fall;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sdi_s;
    logic [RX_BITS-1:0]     rx;
    logic [127:0]           tx;
    logic [RX_CW-1:0]       rx_cnt;
    logic [TX_CW-1:0]       tx_cnt;
    logic                   rx_full_next;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .int_osc  (int_osc),
        .nreset   (nreset),
        .async_in (sck),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load_sync (
        .int_osc  (int_osc),
        .nreset   (nreset),
        .async_in (mcu_load),
        .rise     (load_rise),
        .fall     (load_fall)
    );

    // Data pin synchronizer, same depth as sck so the two stay aligned.
    always_ff @(posedge int_osc or negedge nreset) begin
        if (!nreset) sdi_sync <= '0;
        else         sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
    end

    assign sdi_s = sdi_sync[SYNC_STAGES-1];

    // A shift in the same cycle as the load fall counts toward completion.
    assign rx_full_next = (rx_cnt == RX_CW'(RX_BITS)) ||
                          (sck_rise && (rx_cnt == RX_CW'(RX_BITS - 1)));

`ifdef AES_SPI_TIMEOUT_EN
    logic [23:0] wait_cnt;
    logic        to_flag;
    logic        timeout_hit;

    assign timeout_hit = (state == WAIT) && (wait_cnt == AES_TIMEOUT_MAX) && !core_done;

    // WAIT watchdog and sticky timeout status.
    always_ff @(posedge int_osc or negedge nreset) begin
        if (!nreset) begin
            wait_cnt <= '0;
            to_flag  <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 24'd1 : '0;
            if (load_rise)        to_flag <= 1'b0;
            else if (timeout_hit) to_flag <= 1'b1;
        end
    end

    assign sdo = (state == TX) ? tx[127] : to_flag;
`else
    assign sdo = (state == TX) ? tx[127] : 1'b0;
`endif

    // State register.
    always_ff @(posedge int_osc or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state and core_load decode; a load rise aborts from any state.
    always_comb begin
        state_next = state;
        core_load  = 1'b0;
        case (state)
            IDLE: ;
            RX: begin
                core_load = 1'b1;
                if (load_fall) state_next = rx_full_next ? START : IDLE;
            end
            START: begin
                core_load  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (core_done) state_next = TX;
`ifdef AES_SPI_TIMEOUT_EN
                else if (timeout_hit) state_next = IDLE;
`endif
            end
            TX: begin
                if (sck_fall && (tx_cnt == TX_CW'(TX_BITS - 1))) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (load_rise) state_next = RX;
    end

    // Shift registers, bit counters and the mcu_done flag.
    always_ff @(posedge int_osc or negedge nreset) begin
        if (!nreset) begin
            rx       <= '0;
            tx       <= '0;
            rx_cnt   <= '0;
            tx_cnt   <= '0;
            mcu_done <= 1'b0;
        end else if (load_rise) begin
            rx_cnt   <= '0;
            tx_cnt   <= '0;
            mcu_done <= 1'b0;
        end else begin
            case (state)
                RX: begin
                    if (sck_rise) begin
                        rx <= {rx[RX_BITS-2:0], sdi_s};
                        if (rx_cnt != RX_CW'(RX_BITS)) rx_cnt <= rx_cnt + RX_CW'(1);
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        tx       <= core_cyphertext;
                        mcu_done <= 1'b1;
                    end
                end
                TX: begin
                    if (sck_fall) begin
                        tx     <= {tx[126:0], 1'b0};
                        tx_cnt <= tx_cnt + TX_CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_plaintext = rx[RX_BITS-1 -: 128];
    assign core_key       = rx[127:0];

endmodule

// File: doc/aes_spi_link.md
Name: aes_spi_link

Overview:
SPI-slave front end sitting directly upstream and downstream of the AES core, all in the int_osc domain. It oversamples the MCU's SPI pins and shifts in a 256-bit frame (plaintext then key), drives the core's load/key/plaintext inputs, and waits for core done. It then captures the cyphertext and shifts it back out to the MCU on sdo, asserting a done pin to the MCU while the result is available.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronizers on sck, sdi, mcu_load (legal 2..3)
RX_BITS, 256, frame length in bits; fixed at 256 (128 plaintext + 128 key)
TX_BITS, 128, cyphertext length shifted out

Ports:
int_osc  in  1  system clock, all logic on rising edge
nreset  in  1  asynchronous, active-low reset
sck  in  1  SPI clock from MCU, async to int_osc
sdi  in  1  SPI data MCU->block, async
mcu_load  in  1  frame-active pin from MCU, high during input shift, async
sdo  out  1  SPI data block->MCU
mcu_done  out  1  result-ready pin to MCU
core_load  out  1  load to AES core
core_plaintext  out  128  plaintext to core
core_key  out  128  key to core
core_done  in  1  done from AES core
core_cyphertext  in  128  cyphertext from core

Behaviour:
- Reset: all outputs 0; state IDLE; shift registers, counters, sync chains 0.
- sck, sdi, mcu_load each pass SYNC_STAGES flops; one extra flop on sck_s/load_s for edge detect. Rise/fall are single-cycle pulses. sck high and low phases each must be >= 4 int_osc cycles.
- Protocol is SPI mode 0, MSB first.
- Input frame: plaintext[127] first, key[0] last. Register rx[255:0] shifts left, LSB <= sdi_s, on each sck rise while load_s=1. core_plaintext = rx[255:128], core_key = rx[127:0], driven continuously.
- States and transitions:
  - IDLE: core_load=0. load_s rise -> RX; bit counter cleared.
  - RX: core_load=1. Shift and count on sck rise; counter saturates at 256, and extra bits keep shifting (last 256 win). On load_s fall: count==256 -> START; otherwise -> IDLE (short frame discarded, mcu_done stays 0).
  - START: one cycle, core_load=1, data stable -> WAIT.
  - WAIT: core_load=0. On core_done=1, capture tx <= core_cyphertext, mcu_done <= 1 -> TX.
  - TX: sdo = tx[127] combinationally from the register. On each sck fall, shift tx left, fill with 0, tx count++. After 128 falls -> IDLE. mcu_done holds 1 until the next load_s rise.
- Latency: core_load falls 2 int_osc cycles after load_s fall. mcu_done rises 1 cycle after core_done is sampled high.
- load_s rise in any state (including WAIT/TX) aborts: clear counters, mcu_done <= 0, -> RX. A core_done arriving in the same cycle as an abort is ignored.
- sck edges in IDLE/WAIT: ignored. sck rise and load_s fall in the same cycle: the shift happens first, then the count is checked.
- sdo is 0 outside TX.
- nreset mid-operation: immediate return to reset values. The in-progress frame is lost.

Optional Feature:
- Macro AES_SPI_TIMEOUT_EN.
- Defined: a 24-bit counter runs in WAIT. If it reaches 0xFFFFFF without core_done, go to IDLE with mcu_done=0, and a sticky status bit reported as sdo=1 held through the next TX-less IDLE (cleared on load_s rise).
- Not defined: WAIT waits indefinitely; no counter is synthesized.

Decomposition:
- Package aes_link_pkg: state enum (IDLE, RX, START, WAIT, TX), RX_BITS/TX_BITS constants, timeout constant.
- Sub-module spi_sync_edge: parameterized synchronizer plus rise/fall pulse generator, instantiated for sck and mcu_load (sdi uses sync only).

Test Plan:
- FIPS-197 vector: shift pt 00112233445566778899aabbccddeeff and key 000102030405060708090a0b0c0d0e0f, drop mcu_load; behavioural core returns 69c4e0d86a7b0430d8cdb78070b4c55a after 50 cycles -> core_load 1->0, core_plaintext/core_key match exactly, mcu_done=1, 128 sck clocks read back 69c4e0d8...c55a.
- Short frame of 255 bits then mcu_load low -> no START, core_load returns 0, mcu_done stays 0, state IDLE.
- Overlong frame of 264 bits -> core receives the last 256 bits shifted; normal completion.
- mcu_load raised during TX after 40 bits -> mcu_done drops within SYNC_STAGES+2 cycles, new frame accepted and encrypted correctly.
- nreset pulsed low during WAIT -> all outputs 0 immediately. A later core_done is ignored; the next full frame works.
- With AES_SPI_TIMEOUT_EN: core_done never asserted -> after 2^24-1 WAIT cycles, IDLE, mcu_done=0, sdo=1. Without the macro: remains in WAIT.
